microsequencer: RTL and testbench

- Control-sequencing stage directly upstream of the ALU.
- Steps through T-states and fetches opcode and operand over the shared bus.
- Drives the ALU op select and flag-latch strobe, plus the register/PC/RAM control strobes.
- Consumes the ALU's latched zero/carry/odd flags to resolve conditional jumps.

---
 rtl/microsequencer_pkg.sv | 50 +++++
 rtl/microsequencer_decode.sv | 100 ++++++++++
 rtl/microsequencer.sv | 106 ++++++++++
 tb/tb_microsequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microsequencer_pkg.sv
// Shared constants for the microsequencer: ALU op codes, opcode classes,
// jump conditions and T-state encodings.
package microsequencer_pkg;

  localparam int ALU_OP_WIDTH = 3;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 3'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SL  = 3'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SR  = 3'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ROL = 3'd7;

  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_ALU = 4'h1;
  localparam logic [3:0] OPC_JMP = 4'h2;
  localparam logic [3:0] OPC_HLT = 4'hF;

  localparam logic [1:0] JMP_ALWAYS = 2'd0;
  localparam logic [1:0] JMP_ZERO   = 2'd1;
  localparam logic [1:0] JMP_CARRY  = 2'd2;
  localparam logic [1:0] JMP_ODD    = 2'd3;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  // Instruction field IR[2:0] to ALU operation code.
  function automatic logic [ALU_OP_WIDTH-1:0] alu_op_map(input logic [2:0] sel);
    logic [ALU_OP_WIDTH-1:0] op;
    case (sel)
      3'd0:    op = ALU_ADD;
      3'd1:    op = ALU_SUB;
      3'd2:    op = ALU_AND;
      3'd3:    op = ALU_OR;
      3'd4:    op = ALU_XOR;
      3'd5:    op = ALU_SL;
      3'd6:    op = ALU_SR;
      default: op = ALU_ROL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/microsequencer_decode.sv
// Combinational control-word decode from (tstate, IR, latched ALU flags).
// Only one of pc_out/ram_out/alu_out is ever asserted in a given state.
module microsequencer_decode
  import microsequencer_pkg::*;
(
  input  logic [2:0]              tstate,
  input  logic [7:0]              ir,
  input  logic                    halt,
  input  logic                    zero,
  input  logic                    carry,
  input  logic                    odd,
  output logic                    pc_out,
  output logic                    pc_inc,
  output logic                    pc_in,
  output logic                    mar_in,
  output logic                    ram_out,
  output logic                    t_in,
  output logic                    a_in,
  output logic                    alu_out,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    latch_flags
);

  tstate_e    ts;
  logic [3:0] opc;
  logic       taken;
  logic       unused_ir3;

  assign ts         = tstate_e'(tstate);
  assign opc        = ir[7:4];
  assign unused_ir3 = ir[3];

  always_comb begin
    taken = 1'b0;
    case (ir[1:0])
      JMP_ALWAYS: taken = 1'b1;
      JMP_ZERO:   taken = zero;
      JMP_CARRY:  taken = carry;
      JMP_ODD:    taken = odd;
      default:    taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_out      = 1'b0;
    pc_inc      = 1'b0;
    pc_in       = 1'b0;
    mar_in      = 1'b0;
    ram_out     = 1'b0;
    t_in        = 1'b0;
    a_in        = 1'b0;
    alu_out     = 1'b0;
    alu_op      = ALU_ADD;
    latch_flags = 1'b0;
    // A halted sequencer presents an all-quiet control word.
    if (!halt) begin
      case (ts)
        T0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          if (opc == OPC_ALU || opc == OPC_JMP) begin
            pc_out = 1'b1;
            mar_in = 1'b1;
          end
        end
        T3: begin
          if (opc == OPC_ALU) begin
            ram_out = 1'b1;
            t_in    = 1'b1;
            pc_inc  = 1'b1;
          end else if (opc == OPC_JMP) begin
            // Not-taken jumps just step the PC past the operand byte.
            if (taken) begin
              ram_out = 1'b1;
              pc_in   = 1'b1;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end
        T4: begin
          if (opc == OPC_ALU) begin
            alu_out     = 1'b1;
            a_in        = 1'b1;
            latch_flags = 1'b1;
            alu_op      = alu_op_map(ir[2:0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer top: holds T-state, instruction register and halt flag.
// Build option MICROSEQUENCER_ILLEGAL_TRAP_EN adds a sticky o_illegal trap.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic [WIDTH-1:0]        i_bus,
  input  logic                    i_zero,
  input  logic                    i_carry,
  input  logic                    i_odd,
  output logic                    o_pc_out,
  output logic                    o_pc_inc,
  output logic                    o_pc_in,
  output logic                    o_mar_in,
  output logic                    o_ram_out,
  output logic                    o_t_in,
  output logic                    o_a_in,
  output logic                    o_alu_out,
  output logic [ALU_OP_WIDTH-1:0] o_alu_op,
  output logic                    o_latch_flags,
  output logic                    o_halt,
`ifdef MICROSEQUENCER_ILLEGAL_TRAP_EN
  output logic                    o_illegal,
`endif
  output logic [2:0]              o_tstate
);

  tstate_e    tstate;
  logic [7:0] ir;
  logic       halt;
`ifdef MICROSEQUENCER_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  // Once halted nothing moves until reset, regardless of clk_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstate  <= T0;
      ir      <= 8'h00;
      halt    <= 1'b0;
`ifdef MICROSEQUENCER_ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else if (!halt && clk_en) begin
      case (tstate)
        T0: tstate <= T1;
        T1: begin
          ir     <= i_bus[7:0];
          tstate <= T2;
        end
        T2: begin
          case (ir[7:4])
            OPC_NOP: tstate <= T0;
            OPC_ALU: tstate <= T3;
            OPC_JMP: tstate <= T3;
            OPC_HLT: halt   <= 1'b1;
            default: begin
`ifdef MICROSEQUENCER_ILLEGAL_TRAP_EN
              halt    <= 1'b1;
              illegal <= 1'b1;
`else
              tstate  <= T0;
`endif
            end
          endcase
        end
        T3: begin
          if (ir[7:4] == OPC_ALU) tstate <= T4;
          else                    tstate <= T0;
        end
        T4:      tstate <= T0;
        default: tstate <= T0;
      endcase
    end
  end

  microsequencer_decode u_decode (
    .tstate      (tstate),
    .ir          (ir),
    .halt        (halt),
    .zero        (i_zero),
    .carry       (i_carry),
    .odd         (i_odd),
    .pc_out      (o_pc_out),
    .pc_inc      (o_pc_inc),
    .pc_in       (o_pc_in),
    .mar_in      (o_mar_in),
    .ram_out     (o_ram_out),
    .t_in        (o_t_in),
    .a_in        (o_a_in),
    .alu_out     (o_alu_out),
    .alu_op      (o_alu_op),
    .latch_flags (o_latch_flags)
  );

  assign o_halt   = halt;
  assign o_tstate = tstate;
`ifdef MICROSEQUENCER_ILLEGAL_TRAP_EN
  assign o_illegal = illegal;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: an instruction-level model expands
// each opcode into its expected per-T-state control words.
module tb_microsequencer;

  localparam int W = 16;

  // Control word layout: {tstate[2:0], halt, alu_op[2:0], strobes[8:0]}
  localparam logic [8:0] S_PC_OUT  = 9'h100;
  localparam logic [8:0] S_PC_INC  = 9'h080;
  localparam logic [8:0] S_PC_IN   = 9'h040;
  localparam logic [8:0] S_MAR_IN  = 9'h020;
  localparam logic [8:0] S_RAM_OUT = 9'h010;
  localparam logic [8:0] S_T_IN    = 9'h008;
  localparam logic [8:0] S_A_IN    = 9'h004;
  localparam logic [8:0] S_ALU_OUT = 9'h002;
  localparam logic [8:0] S_LATCH   = 9'h001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic [7:0] i_bus;
  logic       i_zero, i_carry, i_odd;
  logic       o_pc_out, o_pc_inc, o_pc_in, o_mar_in, o_ram_out;
  logic       o_t_in, o_a_in, o_alu_out, o_latch_flags, o_halt;
  logic [2:0] o_alu_op;
  logic [2:0] o_tstate;
`ifdef MICROSEQUENCER_ILLEGAL_TRAP_EN
  logic       o_illegal;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  microsequencer #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_en        (clk_en),
    .i_bus         (i_bus),
    .i_zero        (i_zero),
    .i_carry       (i_carry),
    .i_odd         (i_odd),
    .o_pc_out      (o_pc_out),
    .o_pc_inc      (o_pc_inc),
    .o_pc_in       (o_pc_in),
    .o_mar_in      (o_mar_in),
    .o_ram_out     (o_ram_out),
    .o_t_in        (o_t_in),
    .o_a_in        (o_a_in),
    .o_alu_out     (o_alu_out),
    .o_alu_op      (o_alu_op),
    .o_latch_flags (o_latch_flags),
    .o_halt        (o_halt),
`ifdef MICROSEQUENCER_ILLEGAL_TRAP_EN
    .o_illegal     (o_illegal),
`endif
    .o_tstate      (o_tstate)
  );

  // Clock and reset
  always #5 clk = ~clk;

  wire [W-1:0] obs = {o_tstate, o_halt, o_alu_op,
                      o_pc_out, o_pc_inc, o_pc_in, o_mar_in, o_ram_out,
                      o_t_in, o_a_in, o_alu_out, o_latch_flags};

  function automatic logic [W-1:0] cw(input int t, input logic h,
                                      input logic [2:0] op, input logic [8:0] s);
    logic [2:0] t3;
    t3 = t[2:0];
    return {t3, h, op, s};
  endfunction

  // Reference model: the control words one instruction walks through.
  task automatic model_instr(input logic [7:0] opc, input logic z, input logic c,
                             input logic o);
    logic [3:0] tk;
    exp_q.push_back(cw(0, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN));
    exp_q.push_back(cw(1, 1'b0, 3'd0, S_RAM_OUT | S_PC_INC));
    case (opc[7:4])
      4'h1: begin
        exp_q.push_back(cw(2, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN));
        exp_q.push_back(cw(3, 1'b0, 3'd0, S_RAM_OUT | S_T_IN | S_PC_INC));
        exp_q.push_back(cw(4, 1'b0, opc[2:0], S_ALU_OUT | S_A_IN | S_LATCH));
      end
      4'h2: begin
        tk = {o, c, z, 1'b1};
        exp_q.push_back(cw(2, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN));
        exp_q.push_back(cw(3, 1'b0, 3'd0, tk[opc[1:0]] ? (S_RAM_OUT | S_PC_IN) : S_PC_INC));
      end
      default: exp_q.push_back(cw(2, 1'b0, 3'd0, 9'h000));
    endcase
  endtask

  // Driver: runs up to n_words T-states of one instruction, checking each one,
  // optionally inserting random clk_en stalls with garbage on the bus.
  task automatic drive_instr(input logic [7:0] opc, input logic z, input logic c,
                             input logic o, input int n_words, input bit stalls);
    logic [W-1:0] e;
    exp_q.delete();
    model_instr(opc, z, c, o);
    i_bus = opc; i_zero = z; i_carry = c; i_odd = o; clk_en = 1'b1;
    for (int i = 0; i < n_words && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL instr %02h step %0d: got %04h expected %04h", opc, i, obs, e);
      end
      if (stalls && $urandom_range(0, 3) == 0) begin
        clk_en = 1'b0;
        i_bus = 8'($urandom);
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          checks++;
          if (obs !== e) begin
            errors++;
            $display("FAIL stall %02h step %0d: got %04h expected %04h", opc, i, obs, e);
          end
        end
        clk_en = 1'b1;
        i_bus = opc;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clk_en = 1'b0; i_bus = 8'h00;
    i_zero = 1'b0; i_carry = 1'b0; i_odd = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== cw(0, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN)) begin
      errors++;
      $display("FAIL reset_state: got %04h expected %04h", obs, cw(0, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN));
    end
`ifdef MICROSEQUENCER_ILLEGAL_TRAP_EN
    checks++;
    if (o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal: got %b expected 0", o_illegal);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_alu;
    drive_instr(8'h1A, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    checks++;
    if (obs !== cw(3, 1'b0, 3'd0, S_RAM_OUT | S_T_IN | S_PC_INC)) begin
      errors++;
      $display("FAIL mid_alu_t3: got %04h expected %04h", obs, cw(3, 1'b0, 3'd0, S_RAM_OUT | S_T_IN | S_PC_INC));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== cw(0, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN)) begin
      errors++;
      $display("FAIL mid_alu_reset: got %04h expected %04h", obs, cw(0, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_sub;
    drive_instr(8'h11, 1'b0, 1'b0, 1'b0, 99, 1'b0);
    checks++;
    if (o_tstate !== 3'd0) begin
      errors++;
      $display("FAIL alu_sub_next: tstate %0d expected 0", o_tstate);
    end
  endtask

  task automatic test_jump;
    drive_instr(8'h21, 1'b1, 1'b0, 1'b0, 99, 1'b0);
    drive_instr(8'h21, 1'b0, 1'b1, 1'b1, 99, 1'b0);
    drive_instr(8'h22, 1'b0, 1'b1, 1'b0, 99, 1'b0);
    drive_instr(8'h23, 1'b1, 1'b1, 1'b0, 99, 1'b0);
    drive_instr(8'h20, 1'b0, 1'b0, 1'b0, 99, 1'b0);
    checks++;
    if (o_tstate !== 3'd0) begin
      errors++;
      $display("FAIL jump_next: tstate %0d expected 0", o_tstate);
    end
  endtask

  task automatic test_clk_en_freeze;
    logic [W-1:0] e;
    exp_q.delete();
    model_instr(8'h13, 1'b0, 1'b0, 1'b0);
    i_bus = 8'h13; clk_en = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (i == 1) begin
        clk_en = 1'b0;
        repeat (5) begin
          i_bus = 8'hF0 | 8'($urandom_range(0, 15));
          checks++;
          if (obs !== e) begin
            errors++;
            $display("FAIL freeze_t1: got %04h expected %04h", obs, e);
          end
          @(negedge clk);
        end
        i_bus = 8'h13;
        clk_en = 1'b1;
      end
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL freeze_seq step %0d: got %04h expected %04h", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt;
    drive_instr(8'hF0, 1'b0, 1'b0, 1'b0, 99, 1'b0);
    repeat (10) begin
      clk_en = 1'($urandom_range(0, 1));
      i_bus = 8'($urandom);
      i_zero = 1'($urandom); i_carry = 1'($urandom); i_odd = 1'($urandom);
      checks++;
      if (obs !== cw(2, 1'b1, 3'd0, 9'h000)) begin
        errors++;
        $display("FAIL halted: got %04h expected %04h", obs, cw(2, 1'b1, 3'd0, 9'h000));
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== cw(0, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN)) begin
      errors++;
      $display("FAIL halt_clear: got %04h expected %04h", obs, cw(0, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_illegal;
    drive_instr(8'h50, 1'b0, 1'b0, 1'b0, 99, 1'b0);
`ifdef MICROSEQUENCER_ILLEGAL_TRAP_EN
    checks++;
    if (obs !== cw(2, 1'b1, 3'd0, 9'h000) || o_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_trap: got %04h/%b expected %04h/1", obs, o_illegal, cw(2, 1'b1, 3'd0, 9'h000));
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`else
    checks++;
    if (obs !== cw(0, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN)) begin
      errors++;
      $display("FAIL illegal_nop: got %04h expected %04h", obs, cw(0, 1'b0, 3'd0, S_PC_OUT | S_MAR_IN));
    end
`endif
  endtask

  task automatic test_back_to_back_random;
    logic [7:0] opc;
    logic [3:0] cls;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       cls = 4'h0;
        1:       cls = 4'h1;
        2:       cls = 4'h2;
`ifdef MICROSEQUENCER_ILLEGAL_TRAP_EN
        default: cls = 4'h1;
`else
        default: cls = 4'($urandom_range(3, 14));
`endif
      endcase
      opc = {cls, 4'($urandom_range(0, 15))};
      drive_instr(opc, 1'($urandom), 1'($urandom), 1'($urandom), 99, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_alu_sub();
    test_jump();
    test_reset_mid_alu();
    test_clk_en_freeze();
    test_back_to_back_random();
    test_illegal();
    test_halt();
    test_alu_sub();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
